// File: rtl/pipe_elastic_chain_if.sv
// Handshake bundle for the elastic register chain.
// Master drives the upstream/downstream controls, slave is the chain.
interface pipe_elastic_chain_if #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
);
  localparam int OW = $clog2(STAGES + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [STAGES-1:0] flush_mask;
  logic [OW-1:0]     occupancy;
  logic [15:0]       drop_count;

  modport master (
    output in_valid, in_data, out_ready, flush_mask,
    input  in_ready, out_valid, out_data, occupancy, drop_count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush_mask,
    output in_ready, out_valid, out_data, occupancy, drop_count
  );
endinterface

// File: rtl/pipe_elastic_chain.sv
// Elastic register chain: valid/ready slots with hole collapse,
// per-slot flush, occupancy and saturating drop counter.
module pipe_elastic_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic reset,
  pipe_elastic_chain_if.slave bus
);
  localparam int OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid;
  logic [WIDTH-1:0]  data [STAGES];
  logic              rdyN [STAGES+1];

  assign rdyN[STAGES] = bus.out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : gSlot
    logic             v;
    logic [WIDTH-1:0] d;
    logic             srcValid;
    logic             srcFlush;
    logic [WIDTH-1:0] srcData;
    logic             load;

    if (g == 0) begin : gHead
      assign srcValid = bus.in_valid;
      assign srcFlush = 1'b0;
      assign srcData  = bus.in_data;
    end else begin : gBody
      assign srcValid = valid[g-1];
      assign srcFlush = bus.flush_mask[g-1];
      assign srcData  = data[g-1];
    end

    // Readiness uses unflushed valids so flush never shifts it.
    assign rdyN[g]  = !v | rdyN[g+1];
    assign load     = srcValid & !srcFlush;
    assign valid[g] = v;
    assign data[g]  = d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v <= 1'b0;
        d <= '0;
      end else if (rdyN[g]) begin
        v <= load;
        if (load) d <= srcData;
      end else begin
        v <= v & !bus.flush_mask[g];
      end
    end
  end

  logic [OW-1:0] occ;
  logic [OW-1:0] killed;

  always_comb begin
    occ    = '0;
    killed = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ    = occ + OW'(valid[i]);
      killed = killed + OW'(valid[i] & bus.flush_mask[i]);
    end
  end

  logic [15:0] dropCnt;
  logic [16:0] dropSum;

  assign dropSum = {1'b0, dropCnt} + 17'(killed);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropCnt <= '0;
    end else if (dropSum[16]) begin
      dropCnt <= 16'hFFFF;
    end else begin
      dropCnt <= dropSum[15:0];
    end
  end

  assign bus.in_ready   = rdyN[0];
  assign bus.out_valid  = valid[STAGES-1] & !bus.flush_mask[STAGES-1];
  assign bus.out_data   = data[STAGES-1];
  assign bus.occupancy  = occ;
  assign bus.drop_count = dropCnt;
endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Bench for pipe_elastic_chain: directed scenarios plus random
// traffic against a slot-list reference model.
module tb_pipe_elastic_chain;
  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  pipe_elastic_chain_if #(.WIDTH(W), .STAGES(S)) bus ();

  pipe_elastic_chain #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .reset (rstN),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] dutOut [$];
  int outCyc [$];

  // Reference: list of occupied slots; an item moves forward
  // whenever any slot ahead of it is free or the sink accepts.
  bit          mv [S];
  logic [W-1:0] md [S];
  int          mdrop = 0;

  function automatic int mOcc();
    int n = 0;
    for (int i = 0; i < S; i++) n += int'(mv[i]);
    return n;
  endfunction

  function automatic bit mInRdy();
    return !(mOcc() == S && !bus.out_ready);
  endfunction

  function automatic bit mOutValid();
    return mv[S-1] && !bus.flush_mask[S-1];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < S; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    mdrop = 0;
  endtask

  task automatic modelStep();
    bit          nv [S];
    logic [W-1:0] nd [S];
    bit          inRdy;
    int          k;
    inRdy = mInRdy();
    k = 0;
    for (int i = 0; i < S; i++) begin
      nv[i] = 1'b0;
      nd[i] = md[i];
    end
    for (int i = 0; i < S; i++) begin
      if (mv[i]) begin
        bit room = bus.out_ready;
        for (int j = i + 1; j < S; j++) if (!mv[j]) room = 1'b1;
        if (bus.flush_mask[i]) begin
          k++;
        end else if (room) begin
          if (i < S - 1) begin
            nv[i+1] = 1'b1;
            nd[i+1] = md[i];
          end
        end else begin
          nv[i] = 1'b1;
          nd[i] = md[i];
        end
      end
    end
    mdrop = (mdrop + k > 65535) ? 65535 : mdrop + k;
    if (bus.in_valid && inRdy) begin
      nv[0] = 1'b1;
      nd[0] = bus.in_data;
    end
    for (int i = 0; i < S; i++) begin
      mv[i] = nv[i];
      md[i] = nd[i];
    end
  endtask

  task automatic apply(input bit iv, input logic [W-1:0] id,
                       input bit ordy, input logic [S-1:0] fm);
    @(negedge clk);
    bus.in_valid   = iv;
    bus.in_data    = id;
    bus.out_ready  = ordy;
    bus.flush_mask = fm;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      dutOut.push_back(bus.out_data);
      outCyc.push_back(cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rstN) modelStep();
    cyc++;
  endtask

  task automatic test_reset();
    apply(0, '0, 0, '0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_data !== '0 || bus.occupancy !== 3'd0 ||
        bus.drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b ov=%b od=%h occ=%0d drop=%0d want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data,
               bus.occupancy, bus.drop_count);
    end
    rstN = 1'b1;
    modelReset();
    step();
    for (int i = 0; i < 3; i++) begin
      apply(1, W'(i + 1), 0, '0);
      step();
    end
    apply(0, '0, 0, '0);
    #1 rstN = 1'b0;
    modelReset();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.occupancy !== 3'd0 || bus.drop_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_async: rdy=%b ov=%b occ=%0d drop=%0d want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.occupancy, bus.drop_count);
    end
    step();
    dutOut.delete();
    outCyc.delete();
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply(0, '0, 1, '0);
      step();
    end
    checks++;
    if (dutOut.size() != 0) begin
      failures++;
      $display("FAIL reset_no_emerge: got %0d items want 0", dutOut.size());
    end
  endtask

  task automatic test_stream();
    int c0;
    dutOut.delete();
    outCyc.delete();
    c0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      apply(1, W'(i), 1, '0);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_in_ready: item %0d got %b want 1", i, bus.in_ready);
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      apply(0, '0, 1, '0);
      step();
    end
    checks++;
    if (dutOut.size() != 8) begin
      failures++;
      $display("FAIL stream_count: got %0d want 8", dutOut.size());
    end else begin
      checks++;
      if (outCyc[0] - c0 != S) begin
        failures++;
        $display("FAIL stream_latency: got %0d want %0d", outCyc[0] - c0, S);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dutOut[i] !== W'(i + 1) || outCyc[i] != outCyc[0] + i) begin
          failures++;
          $display("FAIL stream_item%0d: got %h@%0d want %h@%0d", i,
                   dutOut[i], outCyc[i], i + 1, outCyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals [6];
    int n;
    bit acc;
    for (int i = 0; i < 6; i++) vals[i] = W'(32'hA + i);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      apply(1, vals[n], 0, '0);
      acc = bus.in_ready;
      step();
      if (acc) n++;
    end
    apply(1, vals[n], 0, '0);
    checks++;
    if (n != 4 || bus.in_ready !== 1'b0 || bus.occupancy !== 3'd4) begin
      failures++;
      $display("FAIL bp_full: acc=%0d rdy=%b occ=%0d want 4 0 4",
               n, bus.in_ready, bus.occupancy);
    end
    step();
    dutOut.delete();
    outCyc.delete();
    for (int i = 0; i < 12; i++) begin
      apply(n < 6, vals[n < 6 ? n : 5], 1, '0);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) n++;
    end
    checks++;
    if (dutOut.size() != 6) begin
      failures++;
      $display("FAIL bp_count: got %0d want 6", dutOut.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (dutOut[i] !== vals[i] || outCyc[i] != outCyc[0] + i) begin
          failures++;
          $display("FAIL bp_item%0d: got %h@%0d want %h@%0d", i,
                   dutOut[i], outCyc[i], vals[i], outCyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_bubble();
    apply(1, 32'h11, 0, '0);
    step();
    for (int i = 0; i < 2; i++) begin
      apply(0, '0, 0, '0);
      step();
    end
    apply(1, 32'h22, 0, '0);
    step();
    for (int i = 0; i < 3; i++) begin
      apply(0, '0, 0, '0);
      step();
    end
    apply(0, '0, 0, '0);
    checks++;
    if (bus.occupancy !== 3'd2 || bus.out_valid !== 1'b1 ||
        bus.out_data !== 32'h11) begin
      failures++;
      $display("FAIL bubble_settle: occ=%0d ov=%b od=%h want 2 1 11",
               bus.occupancy, bus.out_valid, bus.out_data);
    end
    step();
    dutOut.delete();
    outCyc.delete();
    for (int i = 0; i < 4; i++) begin
      apply(0, '0, 1, '0);
      step();
    end
    checks++;
    if (dutOut.size() != 2 || dutOut[0] !== 32'h11 ||
        dutOut[1] !== 32'h22 || outCyc[1] != outCyc[0] + 1) begin
      failures++;
      $display("FAIL bubble_drain: got %0d items first=%h want 11,22 adjacent",
               dutOut.size(), dutOut.size() > 0 ? dutOut[0] : '0);
    end
  endtask

  task automatic test_flush();
    logic [15:0] d0;
    for (int i = 0; i < 4; i++) begin
      apply(1, W'(32'hA0 + 32'h10 * i), 0, '0);
      step();
    end
    apply(0, '0, 0, 4'b0011);
    d0 = bus.drop_count;
    step();
    apply(0, '0, 0, '0);
    checks++;
    if (bus.occupancy !== 3'd2 || bus.drop_count !== d0 + 16'd2) begin
      failures++;
      $display("FAIL flush_state: occ=%0d drop=%0d want 2 %0d",
               bus.occupancy, bus.drop_count, d0 + 2);
    end
    step();
    dutOut.delete();
    outCyc.delete();
    for (int i = 0; i < 6; i++) begin
      apply(0, '0, 1, '0);
      step();
    end
    checks++;
    if (dutOut.size() != 2 || dutOut[0] !== 32'hA0 || dutOut[1] !== 32'hB0) begin
      failures++;
      $display("FAIL flush_drain: got %0d items first=%h want A0,B0",
               dutOut.size(), dutOut.size() > 0 ? dutOut[0] : '0);
    end
  endtask

  task automatic test_flush_move();
    logic [15:0] d0;
    int c1;
    dutOut.delete();
    outCyc.delete();
    d0 = bus.drop_count;
    apply(1, 32'h55, 1, '0);
    step();
    apply(1, 32'h66, 1, 4'b0001);
    c1 = cyc;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fmove_ready: got %b want 1", bus.in_ready);
    end
    step();
    for (int i = 0; i < 6; i++) begin
      apply(0, '0, 1, '0);
      step();
    end
    checks++;
    if (dutOut.size() != 1 || dutOut[0] !== 32'h66 || outCyc[0] != c1 + S ||
        bus.drop_count !== d0 + 16'd1) begin
      failures++;
      $display("FAIL fmove_result: n=%0d first=%h drop=%0d want 1 66 %0d",
               dutOut.size(), dutOut.size() > 0 ? dutOut[0] : '0,
               bus.drop_count, d0 + 1);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 500; t++) begin
      logic [S-1:0] fm;
      fm = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
      apply(bit'($urandom_range(0, 1)), W'($urandom),
            $urandom_range(0, 3) != 0, fm);
      checks++;
      if (bus.in_ready !== mInRdy() || bus.out_valid !== mOutValid()) begin
        failures++;
        $display("FAIL rand_hs@%0d: rdy=%b ov=%b want %b %b", t,
                 bus.in_ready, bus.out_valid, mInRdy(), mOutValid());
      end
      checks++;
      if (bus.occupancy !== 3'(mOcc()) || bus.drop_count !== 16'(mdrop)) begin
        failures++;
        $display("FAIL rand_cnt@%0d: occ=%0d drop=%0d want %0d %0d", t,
                 bus.occupancy, bus.drop_count, mOcc(), mdrop);
      end
      if (mOutValid()) begin
        checks++;
        if (bus.out_data !== md[S-1]) begin
          failures++;
          $display("FAIL rand_data@%0d: got %h want %h", t,
                   bus.out_data, md[S-1]);
        end
      end
      step();
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.flush_mask = '0;
    modelReset();
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_flush_move();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
